// File: rtl/mux_lfmr_pkg.sv
// mux_lfmr shared helpers: tree sizing and select digit extraction.
// The pipelined demux imports the same functions so paired trees line up.
package mux_lfmr_pkg;

    localparam int MAX_MUX_LOG2 = 16;

    // Smallest power of two m with m**levels >= count.
    function automatic int mux_size_f(input int count, input int levels);
        int     m;
        longint p;
        bit     done;
        m    = 2;
        done = 1'b0;
        for (int t = 0; t < MAX_MUX_LOG2; t++) begin
            if (!done) begin
                p = 1;
                for (int l = 0; l < levels; l++) begin
                    p = p * longint'(m);
                end
                if (p >= longint'(count)) begin
                    done = 1'b1;
                end else begin
                    m = m * 2;
                end
            end
        end
        return m;
    endfunction

    // Number of mux units at a given tree level (level 0 faces the lanes).
    function automatic int level_units_f(
        input int count,
        input int msize,
        input int level
    );
        int n;
        n = count;
        for (int l = 0; l <= level; l++) begin
            n = (n + msize - 1) / msize;
        end
        return n;
    endfunction

    // Digit k of a select value, each digit dw bits wide, digit 0 at the LSB.
    function automatic int digit_f(input int value, input int k, input int dw);
        return (value >> (k * dw)) & ((1 << dw) - 1);
    endfunction

endpackage

// File: rtl/mux_lfmr_if.sv
// mux_lfmr lane bus: pipeline enable, lane inputs with select tag,
// and the registered selected word with its tag.
interface mux_lfmr_if #(
    parameter int WIDTH       = 1,
    parameter int INPUT_COUNT = 2
);

    localparam int SEL_W = $clog2(INPUT_COUNT);

    logic                         ce;
    logic                         valid_in;
    logic [SEL_W-1:0]             sel;
    logic [WIDTH*INPUT_COUNT-1:0] in;
    logic                         valid_out;
    logic [SEL_W-1:0]             sel_out;
    logic                         sel_err;
    logic [WIDTH-1:0]             out;

    modport master (
        output ce, valid_in, sel, in,
        input  valid_out, sel_out, sel_err, out
    );

    modport slave (
        input  ce, valid_in, sel, in,
        output valid_out, sel_out, sel_err, out
    );

endinterface

// File: rtl/mux_lfmr_unit.sv
// mux_unit: combinational MUX_SIZE:1 word selector.
// Inputs at or past N_CONN are treated as zero regardless of what is wired.
module mux_unit #(
    parameter int WIDTH    = 1,
    parameter int MUX_SIZE = 2,
    parameter int N_CONN   = 2,
    parameter int DIGIT_W  = 1
) (
    input  logic [MUX_SIZE-1:0][WIDTH-1:0] d,
    input  logic [DIGIT_W-1:0]             sel,
    output logic [WIDTH-1:0]               y
);

    // Pick the addressed input; unconnected slots fall through to zero.
    always_comb begin
        y = '0;
        for (int j = 0; j < MUX_SIZE; j++) begin
            if (j < N_CONN && DIGIT_W'(j) == sel) begin
                y = d[j];
            end
        end
    end

endmodule

// File: rtl/mux_lfmr.sv
// mux_lfmr: fixed-latency registered N:1 mux built as a tree of
// MUX_SIZE:1 units, one register rank per level, with a tag pipeline.
module mux_lfmr
    import mux_lfmr_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int INPUT_COUNT = 2,
    parameter int LATENCY     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_lfmr_if.slave  bus
);

    localparam int SEL_W    = $clog2(INPUT_COUNT);
    localparam int MUX_SIZE = mux_size_f(INPUT_COUNT, LATENCY);
    localparam int DIGIT_W  = $clog2(MUX_SIZE);
    localparam int EXT_W    = LATENCY * DIGIT_W;
    localparam int MAXU     = level_units_f(INPUT_COUNT, MUX_SIZE, 0);
    localparam int PAD      = MAXU * MUX_SIZE;

    logic [EXT_W-1:0]           ext_sel;
    logic                       err_in;
    logic [MAXU-1:0][WIDTH-1:0] mux_o  [LATENCY];
    logic [MAXU-1:0][WIDTH-1:0] data_q [LATENCY];
    logic [EXT_W-1:0]           rem_q  [LATENCY];
    logic [SEL_W-1:0]           sel_q  [LATENCY];
    logic [LATENCY-1:0]         valid_q;
    logic [LATENCY-1:0]         err_q;

    // Widen sel to whole digits; any lane index past the end is an error.
    always_comb begin
        ext_sel = EXT_W'(bus.sel);
        err_in  = (32'(bus.sel) >= 32'(INPUT_COUNT));
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_lvl
        localparam int NU = level_units_f(INPUT_COUNT, MUX_SIZE, k);
        localparam int NP = (k == 0) ? INPUT_COUNT
                          : level_units_f(INPUT_COUNT, MUX_SIZE, k - 1);

        logic [PAD-1:0][WIDTH-1:0] src;
        logic [DIGIT_W-1:0]        dig;

        if (k == 0) begin : g_src
            // Level 0 is the only place the full lane bus is sampled.
            always_comb begin
                src = '0;
                for (int i = 0; i < NP; i++) begin
                    src[i] = bus.in[i*WIDTH +: WIDTH];
                end
                dig = DIGIT_W'(digit_f(int'(ext_sel), 0, DIGIT_W));
            end
        end else begin : g_src
            // Later levels read the previous rank and its carried digits.
            always_comb begin
                src = '0;
                for (int i = 0; i < NP; i++) begin
                    src[i] = data_q[k-1][i];
                end
                dig = rem_q[k-1][DIGIT_W-1:0];
            end
        end

        for (genvar u = 0; u < MAXU; u++) begin : g_unit
            if (u < NU) begin : g_on
                localparam int LEFT = NP - u * MUX_SIZE;
                localparam int NC   = (LEFT > MUX_SIZE) ? MUX_SIZE : LEFT;
                mux_unit #(
                    .WIDTH    (WIDTH),
                    .MUX_SIZE (MUX_SIZE),
                    .N_CONN   (NC),
                    .DIGIT_W  (DIGIT_W)
                ) u_mux (
                    .d   (src[u*MUX_SIZE +: MUX_SIZE]),
                    .sel (dig),
                    .y   (mux_o[k][u])
                );
            end else begin : g_off
                assign mux_o[k][u] = '0;
            end
        end
    end

    // Data ranks capture the mux result every enabled cycle, valid or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else if (bus.ce) begin
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= mux_o[k];
            end
        end
    end

    // Tag pipeline: valid, remaining digits, original sel and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                rem_q[k] <= '0;
                sel_q[k] <= '0;
            end
        end else if (bus.ce) begin
            valid_q[0] <= bus.valid_in;
            err_q[0]   <= err_in;
            sel_q[0]   <= bus.sel;
            rem_q[0]   <= ext_sel >> DIGIT_W;
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                err_q[k]   <= err_q[k-1];
                sel_q[k]   <= sel_q[k-1];
                rem_q[k]   <= rem_q[k-1] >> DIGIT_W;
            end
        end
    end

    assign bus.out       = data_q[LATENCY-1][0];
    assign bus.valid_out = valid_q[LATENCY-1];
    assign bus.sel_out   = sel_q[LATENCY-1];
    assign bus.sel_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_mux_lfmr.sv
// tb_mux_lfmr: directed checks of mux_lfmr in three configurations
// (5 lanes / 2 levels, 16 lanes / 4 levels, 2 lanes / 1 level).
module tb_mux_lfmr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_lfmr_if #(.WIDTH(8), .INPUT_COUNT(5))  a_if ();
    mux_lfmr_if #(.WIDTH(8), .INPUT_COUNT(16)) b_if ();
    mux_lfmr_if #(.WIDTH(8), .INPUT_COUNT(2))  c_if ();

    mux_lfmr #(.WIDTH(8), .INPUT_COUNT(5), .LATENCY(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    mux_lfmr #(.WIDTH(8), .INPUT_COUNT(16), .LATENCY(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    mux_lfmr #(.WIDTH(8), .INPUT_COUNT(2), .LATENCY(1)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (c_if.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_if.ce = 1'b1; a_if.valid_in = 1'b0; a_if.sel = '0;
        b_if.ce = 1'b1; b_if.valid_in = 1'b0; b_if.sel = '0; b_if.in = '0;
        c_if.ce = 1'b1; c_if.valid_in = 1'b0; c_if.sel = '0; c_if.in = '0;
        for (int i = 0; i < 5; i++) a_if.in[i*8 +: 8] = 8'(8'h10 + i);
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (a_if.out !== 8'h00) begin
            errors++; $display("FAIL reset_out got %h exp 00", a_if.out);
        end
        checks++;
        if (a_if.valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", a_if.valid_out);
        end
        checks++;
        if (a_if.sel_out !== 3'd0 || a_if.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_tag got sel %0d err %b exp 0 0",
                     a_if.sel_out, a_if.sel_err);
        end
        checks++;
        if (b_if.out !== 8'h00 || b_if.valid_out !== 1'b0 ||
            c_if.out !== 8'h00 || c_if.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_bc got b %h/%b c %h/%b exp 00/0",
                     b_if.out, b_if.valid_out, c_if.out, c_if.valid_out);
        end
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_sweep();
        int nvalid = 0;
        for (int n = 0; n < 8; n++) begin
            a_if.valid_in = (n < 5);
            a_if.sel      = (n < 5) ? 3'(n) : 3'd0;
            step();
            if (a_if.valid_out === 1'b1) nvalid++;
            if (n >= 1 && n <= 5) begin
                checks++;
                if (a_if.out !== 8'(8'h10 + n - 1) || a_if.valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_out n=%0d got %h/%b exp %h/1",
                             n, a_if.out, a_if.valid_out, 8'(8'h10 + n - 1));
                end
                checks++;
                if (a_if.sel_out !== 3'(n - 1) || a_if.sel_err !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_tag n=%0d got %0d/%b exp %0d/0",
                             n, a_if.sel_out, a_if.sel_err, n - 1);
                end
            end
        end
        checks++;
        if (nvalid != 5) begin
            errors++; $display("FAIL sweep_count got %0d exp 5", nvalid);
        end
    endtask

    task automatic test_sel_err();
        logic [2:0] sv [4];
        logic [7:0] eo [4];
        logic       ee [4];
        sv[0] = 3'd5; eo[0] = 8'h00; ee[0] = 1'b1;
        sv[1] = 3'd6; eo[1] = 8'h00; ee[1] = 1'b1;
        sv[2] = 3'd7; eo[2] = 8'h00; ee[2] = 1'b1;
        sv[3] = 3'd4; eo[3] = 8'h14; ee[3] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            a_if.valid_in = (n < 4);
            a_if.sel      = (n < 4) ? sv[n] : 3'd0;
            step();
            if (n >= 1) begin
                checks++;
                if (a_if.out !== eo[n-1] || a_if.sel_err !== ee[n-1] ||
                    a_if.sel_out !== sv[n-1] || a_if.valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL sel_err n=%0d got %h/%b/%0d exp %h/%b/%0d",
                             n, a_if.out, a_if.sel_err, a_if.sel_out,
                             eo[n-1], ee[n-1], sv[n-1]);
                end
            end
        end
    endtask

    task automatic test_ce_hold();
        logic pat [5];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        a_if.valid_in = 1'b0;
        a_if.sel      = 3'd0;
        step();
        step();
        for (int n = 0; n < 5; n++) begin
            a_if.ce       = pat[n];
            a_if.valid_in = (n == 0);
            a_if.sel      = (n == 0) ? 3'd3 : 3'd0;
            step();
            if (n == 3) begin
                checks++;
                if (a_if.out !== 8'h13 || a_if.valid_out !== 1'b1 ||
                    a_if.sel_out !== 3'd3) begin
                    errors++;
                    $display("FAIL ce_emerge got %h/%b/%0d exp 13/1/3",
                             a_if.out, a_if.valid_out, a_if.sel_out);
                end
            end else begin
                checks++;
                if (a_if.out !== 8'h10 || a_if.valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL ce_hold n=%0d got %h/%b exp 10/0",
                             n, a_if.out, a_if.valid_out);
                end
            end
        end
        a_if.ce = 1'b1;
    endtask

    task automatic test_reset_mid();
        a_if.valid_in = 1'b1;
        a_if.sel      = 3'd3;
        step();
        a_if.sel = 3'd1;
        step();
        checks++;
        if (a_if.out !== 8'h13 || a_if.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got %h/%b exp 13/1", a_if.out, a_if.valid_out);
        end
        a_if.valid_in = 1'b0;
        a_if.sel      = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_if.out !== 8'h00 || a_if.valid_out !== 1'b0 ||
            a_if.sel_out !== 3'd0 || a_if.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got %h/%b/%0d/%b exp 00/0/0/0",
                     a_if.out, a_if.valid_out, a_if.sel_out, a_if.sel_err);
        end
        step();
        rst_n         = 1'b1;
        a_if.valid_in = 1'b1;
        a_if.sel      = 3'd2;
        step();
        checks++;
        if (a_if.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard got %b/%h exp 0", a_if.valid_out, a_if.out);
        end
        a_if.valid_in = 1'b0;
        a_if.sel      = 3'd0;
        step();
        checks++;
        if (a_if.out !== 8'h12 || a_if.valid_out !== 1'b1 || a_if.sel_out !== 3'd2) begin
            errors++;
            $display("FAIL rst_after got %h/%b/%0d exp 12/1/2",
                     a_if.out, a_if.valid_out, a_if.sel_out);
        end
        step();
        checks++;
        if (a_if.valid_out !== 1'b0) begin
            errors++; $display("FAIL rst_tail got %b exp 0", a_if.valid_out);
        end
    endtask

    task automatic test_random_16();
        logic [7:0] lanes [16];
        logic       hv [1000];
        logic [3:0] hs [1000];
        logic [7:0] hd [1000];
        for (int n = 0; n < 1000; n++) begin
            for (int l = 0; l < 16; l++) begin
                lanes[l] = 8'($urandom);
                b_if.in[l*8 +: 8] = lanes[l];
            end
            b_if.sel      = 4'($urandom_range(0, 15));
            b_if.valid_in = 1'($urandom_range(0, 1));
            hv[n] = b_if.valid_in;
            hs[n] = b_if.sel;
            hd[n] = lanes[b_if.sel];
            step();
            if (n >= 3) begin
                checks++;
                if (b_if.out !== hd[n-3] || b_if.valid_out !== hv[n-3] ||
                    b_if.sel_out !== hs[n-3] || b_if.sel_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rand16 n=%0d got %h/%b/%0d/%b exp %h/%b/%0d/0",
                             n, b_if.out, b_if.valid_out, b_if.sel_out,
                             b_if.sel_err, hd[n-3], hv[n-3], hs[n-3]);
                end
            end
        end
        b_if.valid_in = 1'b0;
    endtask

    task automatic test_two_lane();
        c_if.in       = 16'hAA55;
        c_if.valid_in = 1'b1;
        c_if.sel      = 1'b1;
        step();
        checks++;
        if (c_if.out !== 8'hAA || c_if.valid_out !== 1'b1 || c_if.sel_out !== 1'b1) begin
            errors++;
            $display("FAIL two_sel1 got %h/%b/%0d exp aa/1/1",
                     c_if.out, c_if.valid_out, c_if.sel_out);
        end
        c_if.sel = 1'b0;
        step();
        checks++;
        if (c_if.out !== 8'h55 || c_if.sel_out !== 1'b0 || c_if.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL two_sel0 got %h/%0d/%b exp 55/0/0",
                     c_if.out, c_if.sel_out, c_if.sel_err);
        end
        c_if.valid_in = 1'b0;
        step();
        checks++;
        if (c_if.valid_out !== 1'b0) begin
            errors++; $display("FAIL two_idle got %b exp 0", c_if.valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_sel_err();
        test_ce_hold();
        test_reset_mid();
        test_random_16();
        test_two_lane();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
